cdc_hs_sender: RTL

- Source-domain end of a 4-phase req/ack clock-domain-crossing handshake.
- Accepts one data word per valid/ready transfer and drives a level request with stable data toward the destination domain.
- Holds req and data until the destination's ack, brought back through an internal synchronizer, completes the full 4-phase cycle.
- Pairs with the destination-side level synchronizer that samples req_out.

---
 rtl/cdc_hs_sender.sv | 105 ++++++++++
 1 files changed

// File: rtl/cdc_hs_sender.sv
// Source-domain end of a 4-phase req/ack handshake: takes one word per valid/ready
// transfer and holds req_out/data_out until the synchronized ack has risen and fallen.
module cdc_hs_sender #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;

    // ack_in is asynchronous to clk; only the last synchronizer stage may feed logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s    = ack_sync_q[SYNC_STAGES-1];
    assign in_ready = (state_q == IDLE) && !ack_s;
    assign busy     = (state_q != IDLE);
    assign req_out  = req_q;
    assign data_out = data_q;
    assign done     = done_q;
    assign xfer_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ACK_LOW;
                end
            end
            ACK_LOW: begin
                // The handshake only completes once the destination has released ack
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule
